// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the fetch/data memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_e;

    localparam int MEM_LAT_DEF = 2;
    localparam int AW_DEF      = 32;
    localparam int DW_DEF      = 32;

endpackage

// File: rtl/arb_rr2.sv
// Two-way arbiter: bit 0 = fetch, bit 1 = data; one-hot grant.
module arb_rr2 (
    input  logic [1:0] i_req,
    input  logic       i_prio,
    input  logic       i_ptr,
    output logic [1:0] o_gnt
);

    always_comb begin
        o_gnt = 2'b00;
        unique case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            // Conflict: fixed data priority, or the side the pointer does not name
            2'b11:   o_gnt = (i_prio || !i_ptr) ? 2'b10 : 2'b01;
            default: o_gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for a single-ported unified memory, one outstanding access.
// Optional statistics counters: define MEM_ARBITER_STATS_EN.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MEM_LAT   = MEM_LAT_DEF,
    parameter int DATA_PRIO = 0,
    parameter int AW        = AW_DEF,
    parameter int DW        = DW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
`ifdef MEM_ARBITER_STATS_EN
    output logic [31:0]   stat_i_cnt,
    output logic [31:0]   stat_d_cnt,
    output logic [31:0]   stat_conflict_cnt,
`endif
    input  logic [DW-1:0] m_rdata
);

    localparam int CW = $clog2(MEM_LAT + 1);
    localparam logic [CW-1:0] LAT_M1 = CW'(MEM_LAT - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    state_e        r_state;
    state_e        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    owner_e        r_owner;
    owner_e        w_owner_nxt;
    owner_e        r_ptr;
    owner_e        w_ptr_nxt;
    logic          r_we;
    logic          w_we_nxt;
    logic [DW-1:0] r_i_rdata;
    logic [DW-1:0] r_d_rdata;

    logic [1:0]    w_arb_gnt;
    logic          w_idle;
    logic          w_resp;
    logic          w_gi;
    logic          w_gd;

    arb_rr2 u_arb (
        .i_req  ({d_req, i_req}),
        .i_prio (DATA_PRIO != 0),
        .i_ptr  (r_ptr),
        .o_gnt  (w_arb_gnt)
    );

    // Outputs are held quiet while reset is asserted
    assign w_idle = reset && (r_state == IDLE);
    assign w_resp = reset && (r_state == RESP);
    assign w_gi   = w_idle && w_arb_gnt[0];
    assign w_gd   = w_idle && w_arb_gnt[1];

    assign i_gnt    = w_gi;
    assign d_gnt    = w_gd;
    assign m_en     = w_gi || w_gd;
    assign m_we     = w_gd && d_we;
    assign m_addr   = w_gd ? d_addr : (w_gi ? i_addr : '0);
    assign m_wdata  = w_gd ? d_wdata : '0;

    assign i_rvalid = w_resp && (r_owner == OWN_FETCH);
    assign d_rvalid = w_resp && (r_owner == OWN_DATA);
    assign i_rdata  = i_rvalid ? m_rdata : r_i_rdata;
    assign d_rdata  = (d_rvalid && !r_we) ? m_rdata : r_d_rdata;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_we_nxt    = r_we;
        unique case (r_state)
            IDLE: begin
                if (m_en) begin
                    w_owner_nxt = w_gd ? OWN_DATA : OWN_FETCH;
                    w_we_nxt    = m_we;
                    w_cnt_nxt   = LAT_M1;
                    w_state_nxt = (MEM_LAT == 1) ? RESP : BUSY;
                    if (i_req && d_req) begin
                        w_ptr_nxt = w_gd ? OWN_DATA : OWN_FETCH;
                    end
                end
            end
            BUSY: begin
                w_cnt_nxt = r_cnt - CNT_ONE;
                if (r_cnt == CNT_ONE) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_owner   <= OWN_FETCH;
            r_ptr     <= OWN_FETCH;
            r_we      <= 1'b0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            r_we    <= w_we_nxt;
            if (i_rvalid) begin
                r_i_rdata <= m_rdata;
            end
            if (d_rvalid && !r_we) begin
                r_d_rdata <= m_rdata;
            end
        end
    end

`ifdef MEM_ARBITER_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_i_cnt        <= '0;
            stat_d_cnt        <= '0;
            stat_conflict_cnt <= '0;
        end else begin
            if (w_gi) begin
                stat_i_cnt <= stat_i_cnt + 32'd1;
            end
            if (w_gd) begin
                stat_d_cnt <= stat_d_cnt + 32'd1;
            end
            if (i_req && d_req) begin
                stat_conflict_cnt <= stat_conflict_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: round-robin instance (a) and data-priority instance (b), MEM_LAT=2.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;

    logic        a_i_gnt, a_i_rvalid, a_d_gnt, a_d_rvalid, a_m_en, a_m_we;
    logic [31:0] a_i_rdata, a_d_rdata, a_m_addr, a_m_wdata, a_m_rdata;
    logic        b_i_gnt, b_i_rvalid, b_d_gnt, b_d_rvalid, b_m_en, b_m_we;
    logic [31:0] b_i_rdata, b_d_rdata, b_m_addr, b_m_wdata, b_m_rdata;
    logic [31:0] a_a1 = '0, a_a2 = '0, b_a1 = '0, b_a2 = '0;

`ifdef MEM_ARBITER_STATS_EN
    logic [31:0] a_si, a_sd, a_sc, b_si, b_sd, b_sc;
`endif

    int n_run = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a == 32'h100) ? 32'hE3A00001 : (a ^ 32'hA5A50000);
    endfunction

    // Memory model: read data appears two cycles after the strobe cycle
    always @(posedge clk) begin
        a_a1 <= a_m_addr;
        a_a2 <= a_a1;
        b_a1 <= b_m_addr;
        b_a2 <= b_a1;
    end
    assign a_m_rdata = memf(a_a2);
    assign b_m_rdata = memf(b_a2);

    mem_arbiter #(.MEM_LAT(2), .DATA_PRIO(0), .AW(32), .DW(32)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(a_i_gnt),
        .i_rvalid(a_i_rvalid), .i_rdata(a_i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
        .m_en(a_m_en), .m_we(a_m_we), .m_addr(a_m_addr), .m_wdata(a_m_wdata),
`ifdef MEM_ARBITER_STATS_EN
        .stat_i_cnt(a_si), .stat_d_cnt(a_sd), .stat_conflict_cnt(a_sc),
`endif
        .m_rdata(a_m_rdata)
    );

    mem_arbiter #(.MEM_LAT(2), .DATA_PRIO(1), .AW(32), .DW(32)) dut_p (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(b_i_gnt),
        .i_rvalid(b_i_rvalid), .i_rdata(b_i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
        .m_en(b_m_en), .m_we(b_m_we), .m_addr(b_m_addr), .m_wdata(b_m_wdata),
`ifdef MEM_ARBITER_STATS_EN
        .stat_i_cnt(b_si), .stat_d_cnt(b_sd), .stat_conflict_cnt(b_sc),
`endif
        .m_rdata(b_m_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] exp_a;
        logic [1:0] exp_b;

        // Reset held with both sides requesting
        i_req = 1'b1; d_req = 1'b1; i_addr = 32'h100; d_addr = 32'h64;
        d_wdata = 32'h55;
        for (int k = 0; k < 3; k++) begin
            drive_edge();
            @(negedge clk);
            chk("rst_gnt", 64'({a_i_gnt, a_d_gnt, b_i_gnt, b_d_gnt}), 64'd0);
            chk("rst_mem", 64'({a_m_en, a_m_we, b_m_en, b_m_we}), 64'd0);
            chk("rst_addr", 64'({a_m_addr, a_m_wdata}), 64'd0);
            chk("rst_rv", 64'({a_i_rvalid, a_d_rvalid, b_i_rvalid, b_d_rvalid}), 64'd0);
            chk("rst_rdata", 64'({a_i_rdata, a_d_rdata}), 64'd0);
        end
        drive_edge();
        reset = 1'b1; i_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        chk("rel_idle", 64'({a_i_gnt, a_d_gnt, a_m_en}), 64'd0);

        // Single fetch
        drive_edge();
        i_req = 1'b1; i_addr = 32'h100;
        @(negedge clk);
        chk("f_gnt", 64'({a_i_gnt, a_d_gnt, a_m_en, a_m_we}), 64'b1010);
        chk("f_addr", 64'(a_m_addr), 64'h100);
        drive_edge();
        i_req = 1'b0;
        @(negedge clk);
        chk("f_busy", 64'({a_i_rvalid, a_m_en, a_i_gnt}), 64'd0);
        drive_edge();
        @(negedge clk);
        chk("f_rv", 64'({a_i_rvalid, a_d_rvalid}), 64'b10);
        chk("f_rdata", 64'(a_i_rdata), 64'hE3A00001);
        drive_edge();
        @(negedge clk);
        chk("f_rv_off", 64'(a_i_rvalid), 64'd0);
        chk("f_hold", 64'(a_i_rdata), 64'hE3A00001);

        // Data write
        drive_edge();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h64; d_wdata = 32'h7;
        @(negedge clk);
        chk("w_gnt", 64'({a_i_gnt, a_d_gnt, a_m_en, a_m_we}), 64'b0111);
        chk("w_bus", 64'({a_m_addr, a_m_wdata}), {32'h64, 32'h7});
        drive_edge();
        d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        chk("w_busy", 64'({a_d_rvalid, a_m_en}), 64'd0);
        drive_edge();
        @(negedge clk);
        chk("w_rv", 64'({a_i_rvalid, a_d_rvalid}), 64'b01);
        chk("w_rdata", 64'(a_d_rdata), 64'd0);

        // Data read issued in the following idle cycle
        drive_edge();
        d_req = 1'b1; d_addr = 32'h200;
        @(negedge clk);
        chk("r_gnt", 64'({a_d_gnt, a_d_rvalid, a_m_we}), 64'b100);
        drive_edge();
        d_req = 1'b0;
        @(negedge clk);
        drive_edge();
        @(negedge clk);
        chk("r_rv", 64'(a_d_rvalid), 64'd1);
        chk("r_rdata", 64'(a_d_rdata), 64'hA5A50200);
        drive_edge();
        @(negedge clk);
        chk("r_hold", 64'({a_d_rvalid, a_d_rdata}), 64'hA5A50200);

        // Continuous conflict: a grants D,I,D,I; b grants only D
        for (int c = 0; c < 12; c++) begin
            drive_edge();
            i_req = 1'b1; d_req = 1'b1; i_addr = 32'h300; d_addr = 32'h400;
            @(negedge clk);
            exp_a = 2'b00;
            exp_b = 2'b00;
            if (c % 3 == 0) begin
                exp_a = ((c / 3) % 2 == 0) ? 2'b01 : 2'b10;
                exp_b = 2'b01;
            end
            chk("rr_gnt", 64'({a_i_gnt, a_d_gnt}), 64'(exp_a));
            chk("prio_gnt", 64'({b_i_gnt, b_d_gnt}), 64'(exp_b));
            if (c % 3 == 2) begin
                exp_a = ((c / 3) % 2 == 0) ? 2'b01 : 2'b10;
                chk("rr_rv", 64'({a_i_rvalid, a_d_rvalid}), 64'(exp_a));
                chk("prio_rv", 64'({b_i_rvalid, b_d_rvalid}), 64'b01);
            end
        end
        drive_edge();
        i_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        chk("rr_irdata", 64'(a_i_rdata), 64'hA5A50300);
        chk("prio_irdata", 64'(b_i_rdata), 64'hE3A00001);

        // Reset one cycle after a data grant aborts the access
        drive_edge();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
        @(negedge clk);
        chk("mr_gnt", 64'({a_d_gnt, b_d_gnt}), 64'b11);
        drive_edge();
        d_req = 1'b0; reset = 1'b0;
        @(negedge clk);
        chk("mr_rv0", 64'({a_d_rvalid, b_d_rvalid}), 64'd0);
        drive_edge();
        reset = 1'b1;
        @(negedge clk);
        chk("mr_rv1", 64'({a_d_rvalid, b_d_rvalid, a_m_en}), 64'd0);
        chk("mr_rdata", 64'(a_d_rdata), 64'd0);
        drive_edge();
        @(negedge clk);
        chk("mr_rv2", 64'({a_d_rvalid, b_d_rvalid}), 64'd0);
        drive_edge();
        d_req = 1'b1;
        @(negedge clk);
        chk("mr_regnt", 64'({a_d_gnt, b_d_gnt}), 64'b11);
        drive_edge();
        d_req = 1'b0;
        @(negedge clk);
        drive_edge();
        @(negedge clk);
        chk("mr_rv", 64'({a_d_rvalid, b_d_rvalid}), 64'b11);
        chk("mr_data", 64'(a_d_rdata), 64'hA5A50500);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
